// File: rtl/regfile_alu_dec_if.sv
// Bundles the register-file, ALU and decoder signals of regfile_alu_dec.
// The master drives operands and indices; the slave (the block) returns results.
interface regfile_alu_dec_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic              alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        dec_in;
  logic [7:0]        dec_out;

  modport master (
    output wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, dec_in,
    input  rdata1, rdata2, alu_result, dec_out
  );

  modport slave (
    input  wen, waddr, wdata, raddr1, raddr2, alu_src1, alu_src2, alu_op, dec_in,
    output rdata1, rdata2, alu_result, dec_out
  );
endinterface

// File: rtl/regfile_alu_dec.sv
// Two-read/one-write register file with a hard-wired zero register,
// plus an independent combinational adder and 3-to-8 one-hot decoder.
module regfile_alu_dec #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  regfile_alu_dec_if.slave   bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  // NOTE: the array gets an asynchronous clear because every register must read
  // zero the instant reset drops; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wen && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Reads see the stored value only, so a write becomes visible after its edge.
  assign bus.rdata1 = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];

  assign bus.alu_result = bus.alu_op ? (bus.alu_src1 + bus.alu_src2) : '0;

  always_comb begin
    bus.dec_out = 8'd1 << bus.dec_in;
  end

endmodule

// File: tb/tb_regfile_alu_dec.sv
// Scoreboard bench for regfile_alu_dec: stimulus pushes expected outputs from a
// behavioural model into a queue; a monitor pops and compares against the DUT.
module tb_regfile_alu_dec;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] alu;
    logic [7:0]        dec;
  } exp_t;

  logic clk;
  logic reset;

  regfile_alu_dec_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_alu_dec #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mdl [NREG];
  exp_t exp_q[$];
  event mon_ev;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: compares every queued expectation against the settled DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".rdata1"}, bus.rdata1, e.r1);
        check({e.name, ".rdata2"}, bus.rdata2, e.r2);
        check({e.name, ".alu"}, bus.alu_result, e.alu);
        check({e.name, ".dec"}, {24'd0, bus.dec_out}, {24'd0, e.dec});
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) mdl[i] = '0;
  endtask

  // Expected outputs straight from the functional rules.
  task automatic sample(input string nm);
    exp_t       e;
    logic [63:0] sum;
    #1;
    sum    = (64'(bus.alu_src1) + 64'(bus.alu_src2)) % 64'h1_0000_0000;
    e.name = nm;
    e.r1   = mdl[bus.raddr1];
    e.r2   = mdl[bus.raddr2];
    e.alu  = bus.alu_op ? sum[DATA_W-1:0] : '0;
    e.dec  = 8'(2 ** int'(bus.dec_in));
    exp_q.push_back(e);
    -> mon_ev;
    #1;
  endtask

  // One rising edge: a write lands when reset is high, wen is set and index != 0.
  task automatic tick();
    @(posedge clk);
    if (reset && bus.wen && bus.waddr != '0) mdl[bus.waddr] = bus.wdata;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wen   = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    bus.wen   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    bus.wen      = 1'b1;
    bus.waddr    = 5'd3;
    bus.wdata    = 32'hA5A5_A5A5;
    bus.raddr1   = '0;
    bus.raddr2   = '0;
    bus.alu_src1 = '0;
    bus.alu_src2 = '0;
    bus.alu_op   = 1'b0;
    bus.dec_in   = '0;
    model_clear();

    // Reset held with a pending write: every index reads zero.
    for (int i = 0; i < NREG; i++) begin
      bus.raddr1 = ADDR_W'(i);
      bus.raddr2 = ADDR_W'(NREG - 1 - i);
      sample("reset_sweep");
    end
    @(negedge clk);
    bus.wen = 1'b0;
    reset   = 1'b1;

    // Write 5, both ports on 5: old value before the edge, new one after.
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd5;
    bus.wen    = 1'b1;
    bus.waddr  = 5'd5;
    bus.wdata  = 32'hDEAD_BEEF;
    sample("wr5_before_edge");
    tick();
    bus.wen = 1'b0;
    sample("wr5_after_edge");

    // Index 0 ignores writes.
    bus.raddr1 = 5'd0;
    do_write(5'd0, 32'h1234_5678);
    sample("reg0_write");

    // Adder wrap, plain add, and op=0.
    bus.alu_op = 1'b1; bus.alu_src1 = 32'hFFFF_FFFF; bus.alu_src2 = 32'h0000_0001;
    sample("alu_wrap");
    bus.alu_src1 = 32'h8000_0000; bus.alu_src2 = 32'h0000_0004;
    sample("alu_add");
    bus.alu_op = 1'b0; bus.alu_src1 = 32'h1357_9BDF; bus.alu_src2 = 32'h2468_ACE0;
    sample("alu_off");

    for (int i = 0; i < 8; i++) begin
      bus.dec_in = 3'(i);
      sample("dec_sweep");
    end

    // wen low: nothing changes even with a live index and data.
    bus.waddr = 5'd5; bus.wdata = 32'h0BAD_F00D;
    tick();
    bus.raddr1 = 5'd5;
    sample("wen_low");

    // Fill 1..31 with their own index, then pulse reset between edges.
    for (int i = 1; i < NREG; i++) do_write(ADDR_W'(i), DATA_W'(i));
    for (int i = 0; i < NREG; i += 4) begin
      bus.raddr1 = ADDR_W'(i);
      bus.raddr2 = ADDR_W'(i + 3);
      sample("fill_check");
    end
    #2;
    reset = 1'b0;
    model_clear();
    bus.wen = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hCAFE_0007;
    bus.raddr1 = 5'd7; bus.raddr2 = 5'd31;
    sample("midrun_reset_now");
    @(posedge clk);
    @(negedge clk);
    sample("midrun_reset_wen");
    bus.alu_op = 1'b1; bus.alu_src1 = 32'd10; bus.alu_src2 = 32'd20; bus.dec_in = 3'd6;
    sample("midrun_reset_alu_dec");
    reset   = 1'b1;
    bus.wen = 1'b0;
    sample("after_reset_release");
    do_write(5'd7, 32'hCAFE_0007);
    sample("first_write_after_reset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.wen      = 1'($urandom_range(0, 1));
      bus.waddr    = ADDR_W'($urandom_range(0, NREG - 1));
      bus.wdata    = $urandom;
      bus.raddr1   = ($urandom_range(0, 3) == 0) ? bus.waddr : ADDR_W'($urandom_range(0, NREG - 1));
      bus.raddr2   = ($urandom_range(0, 3) == 0) ? bus.raddr1 : ADDR_W'($urandom_range(0, NREG - 1));
      bus.alu_op   = 1'($urandom_range(0, 1));
      bus.alu_src1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.alu_src2 = $urandom;
      bus.dec_in   = 3'($urandom_range(0, 7));
      sample("random");
      tick();
    end
    bus.wen = 1'b0;
    sample("random_final");

    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_alu_dec.md
REGFILE_ALU_DEC -- requirements
Module: regfile_alu_dec

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register, ALU operand and result width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register address width; register count = 2^ADDR_W = 32.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port wen, input, 1, register write enable.
REQ-006 The block SHALL have port waddr, input, ADDR_W, write register index.
REQ-007 The block SHALL have port wdata, input, DATA_W, write data.
REQ-008 The block SHALL have ports raddr1 and raddr2, input, ADDR_W each, read indices for ports 1 and 2.
REQ-009 The block SHALL have ports rdata1 and rdata2, output, DATA_W each, read data for ports 1 and 2.
REQ-010 The block SHALL have ports alu_src1 and alu_src2, input, DATA_W each, ALU operands.
REQ-011 The block SHALL have port alu_op, input, 1, ALU operation select; bit 0 = add.
REQ-012 The block SHALL have port alu_result, output, DATA_W, ALU result.
REQ-013 The block SHALL have port dec_in, input, 3, binary code for the 3-to-8 decoder.
REQ-014 The block SHALL have port dec_out, output, 8, one-hot decoder output.

Function
REQ-015 Register file: 32 registers of DATA_W bits; register 0 SHALL always read as 0.
REQ-016 Write: on a rising clk edge with reset high, wen=1 and waddr!=0, register[waddr] <= wdata; writes to index 0 SHALL be discarded.
REQ-017 With wen=0, no register SHALL change.
REQ-018 Reads: rdata1 = register[raddr1] and rdata2 = register[raddr2], both combinational, zero-cycle latency, independent of clk.
REQ-019 Same-cycle read of the address being written SHALL return the old value until the edge; the new value SHALL appear right after the edge. There is no write-to-read bypass.
REQ-020 Both read ports MAY address the same register; both SHALL return the same value.
REQ-021 ALU with alu_op[0]=1: alu_result = (alu_src1 + alu_src2) mod 2^DATA_W; carry out is dropped and there is no overflow flag.
REQ-022 ALU with alu_op[0]=0: alu_result = 0.
REQ-023 The ALU SHALL be purely combinational and SHALL not depend on clk or reset.
REQ-024 Decoder: dec_out[i] = 1 exactly when dec_in == i, for i = 0..7; exactly one bit is set at all times; purely combinational.
REQ-025 Unknown or X inputs carry no requirement; every defined input SHALL produce a defined output.

Reset
REQ-026 While reset=0, all 32 registers SHALL clear to 0 immediately (asynchronous), so rdata1 and rdata2 read 0 for any address.
REQ-027 A write with wen=1 while reset=0 SHALL be ignored.
REQ-028 On reset deassertion, the first write SHALL take effect at the first rising clk edge with reset=1.
REQ-029 Reset asserted mid-operation SHALL clear all prior contents; alu_result and dec_out SHALL be unaffected by reset.

Verification
REQ-030 Reset: hold reset=0, then sweep raddr1 and raddr2 over 0..31 -> every read returns 0x00000000.
REQ-031 Write/read: write 0xDEADBEEF to register 5, then set raddr1=5 and raddr2=5 -> both return 0xDEADBEEF; in the write cycle, before the edge, they return 0.
REQ-032 Register 0: write 0x12345678 to register 0 -> raddr1=0 returns 0x00000000.
REQ-033 ALU: alu_op=1 with inputs 0xFFFFFFFF + 0x00000001 -> 0x00000000; inputs 0x80000000 + 0x00000004 -> 0x80000004; alu_op=0 with any inputs -> 0.
REQ-034 Decoder: dec_in 0..7 -> dec_out 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80.
REQ-035 Mid-run reset: fill registers 1..31 with their index values, pulse reset=0 between clock edges -> all registers read 0 immediately, and wen=1 during reset has no effect.
